// File: rtl/strat_pkg.sv
// Shared types, book constants and the imbalance compare for the imbalance strategy kernel.
package strat_pkg;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  // Sentinel prices, truncated to the price width at the point of use.
  localparam logic [63:0] PRICE_EMPTY_BID = '0;
  localparam logic [63:0] PRICE_EMPTY_ASK = '1;

  localparam int CMP_W = 64;

  // True when a*den > b*num; products are widened so nothing is truncated.
  function automatic logic imb_cmp(input logic [CMP_W-1:0] a,
                                   input logic [CMP_W-1:0] b,
                                   input logic [15:0]      num,
                                   input logic [15:0]      den);
    logic [CMP_W+15:0] lhs;
    logic [CMP_W+15:0] rhs;
    lhs = {16'b0, a} * {{CMP_W{1'b0}}, den};
    rhs = {16'b0, b} * {{CMP_W{1'b0}}, num};
    return lhs > rhs;
  endfunction

endpackage

// File: rtl/strategy_kernel_imb_fsm_if.sv
// Book-update input bus and ready/valid order output bus of the imbalance kernel.
interface strategy_kernel_imb_fsm_if #(
  parameter int PRICE_W = 32,
  parameter int QTY_W   = 32
);
  logic               book_valid;
  logic [PRICE_W-1:0] best_bid_price;
  logic [QTY_W-1:0]   best_bid_qty;
  logic [PRICE_W-1:0] best_ask_price;
  logic [QTY_W-1:0]   best_ask_qty;

  logic               ord_valid;
  logic               ord_ready;
  logic               ord_side;
  logic [PRICE_W-1:0] ord_price;
  logic [QTY_W-1:0]   ord_qty;

  // The kernel is the master: it consumes the book and offers orders.
  modport master (
    input  book_valid, best_bid_price, best_bid_qty, best_ask_price, best_ask_qty,
    input  ord_ready,
    output ord_valid, ord_side, ord_price, ord_qty
  );

  modport slave (
    output book_valid, best_bid_price, best_bid_qty, best_ask_price, best_ask_qty,
    output ord_ready,
    input  ord_valid, ord_side, ord_price, ord_qty
  );
endinterface

// File: rtl/strat_imb_eval.sv
// Evaluation stage: book sanity, NUM/DEN imbalance compare, side/price/qty pick, one register stage.
module strat_imb_eval
  import strat_pkg::*;
#(
  parameter int PRICE_W   = 32,
  parameter int QTY_W     = 32,
  parameter int IMB_NUM   = 3,
  parameter int IMB_DEN   = 2,
  parameter int QTY_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               book_valid,
  input  logic [PRICE_W-1:0] bid_price,
  input  logic [QTY_W-1:0]   bid_qty,
  input  logic [PRICE_W-1:0] ask_price,
  input  logic [QTY_W-1:0]   ask_qty,
  output logic               e_valid,
  output side_e              e_side,
  output logic [PRICE_W-1:0] e_price,
  output logic [QTY_W-1:0]   e_raw_qty
);

  logic               book_ready;
  logic               buy;
  logic               sell;
  logic               e_valid_q,   e_valid_d;
  side_e              e_side_q,    e_side_d;
  logic [PRICE_W-1:0] e_price_q,   e_price_d;
  logic [QTY_W-1:0]   e_raw_qty_q, e_raw_qty_d;

  always_comb begin
    book_ready = (bid_price != PRICE_W'(PRICE_EMPTY_BID)) &&
                 (ask_price != PRICE_W'(PRICE_EMPTY_ASK)) &&
                 (bid_price < ask_price);
    buy  = book_ready && imb_cmp(CMP_W'(bid_qty), CMP_W'(ask_qty), 16'(IMB_NUM), 16'(IMB_DEN));
    sell = book_ready && imb_cmp(CMP_W'(ask_qty), CMP_W'(bid_qty), 16'(IMB_NUM), 16'(IMB_DEN));

    e_valid_d   = book_valid && (buy || sell);
    e_side_d    = e_side_q;
    e_price_d   = e_price_q;
    e_raw_qty_d = e_raw_qty_q;
    // BUY takes priority when both sides clear the threshold.
    if (book_valid && buy) begin
      e_side_d    = SIDE_BUY;
      e_price_d   = ask_price;
      e_raw_qty_d = bid_qty >> QTY_SHIFT;
    end else if (book_valid && sell) begin
      e_side_d    = SIDE_SELL;
      e_price_d   = bid_price;
      e_raw_qty_d = ask_qty >> QTY_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q   <= 1'b0;
      e_side_q    <= SIDE_BUY;
      e_price_q   <= '0;
      e_raw_qty_q <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_side_q    <= e_side_d;
      e_price_q   <= e_price_d;
      e_raw_qty_q <= e_raw_qty_d;
    end
  end

  assign e_valid   = e_valid_q;
  assign e_side    = e_side_q;
  assign e_price   = e_price_q;
  assign e_raw_qty = e_raw_qty_q;

endmodule

// File: rtl/strategy_kernel_imb_fsm.sv
// Imbalance strategy kernel: order FSM with ready/valid offer, cooldown, position-limit clipping and drop count.
module strategy_kernel_imb_fsm
  import strat_pkg::*;
#(
  parameter int PRICE_W      = 32,
  parameter int QTY_W        = 32,
  parameter int IMB_NUM      = 3,
  parameter int IMB_DEN      = 2,
  parameter int QTY_SHIFT    = 1,
  parameter int COOLDOWN_CYC = 16,
  parameter int MAX_POS      = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  strategy_kernel_imb_fsm_if.master bus,
  output logic signed [QTY_W+1:0] position,
  output logic [15:0]             drop_cnt,
  output logic                    busy
);

  localparam int HW    = QTY_W + 3;
  localparam int CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic signed [HW-1:0] MAX_POS_S = HW'(MAX_POS);

  logic               e_valid;
  side_e              e_side;
  logic [PRICE_W-1:0] e_price;
  logic [QTY_W-1:0]   e_raw_qty;

  state_e                  state_q,     state_d;
  logic                    ord_valid_q, ord_valid_d;
  side_e                   ord_side_q,  ord_side_d;
  logic [PRICE_W-1:0]      ord_price_q, ord_price_d;
  logic [QTY_W-1:0]        ord_qty_q,   ord_qty_d;
  logic signed [QTY_W+1:0] position_q,  position_d;
  logic [15:0]             drop_cnt_q,  drop_cnt_d;
  logic                    busy_q,      busy_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;

  logic               handshake;
  logic signed [HW-1:0] pend_delta;
  logic signed [HW-1:0] pos_eff;
  logic signed [HW-1:0] headroom;
  logic signed [HW-1:0] raw_ext;
  logic [QTY_W-1:0]   clip_qty;
  logic               take;

  strat_imb_eval #(
    .PRICE_W   (PRICE_W),
    .QTY_W     (QTY_W),
    .IMB_NUM   (IMB_NUM),
    .IMB_DEN   (IMB_DEN),
    .QTY_SHIFT (QTY_SHIFT)
  ) u_eval (
    .clk        (clk),
    .rst_n      (rst_n),
    .book_valid (bus.book_valid),
    .bid_price  (bus.best_bid_price),
    .bid_qty    (bus.best_bid_qty),
    .ask_price  (bus.best_ask_price),
    .ask_qty    (bus.best_ask_qty),
    .e_valid    (e_valid),
    .e_side     (e_side),
    .e_price    (e_price),
    .e_raw_qty  (e_raw_qty)
  );

  always_comb begin
    handshake  = ord_valid_q && bus.ord_ready;
    pend_delta = '0;
    if (handshake) begin
      pend_delta = (ord_side_q == SIDE_BUY) ?  $signed({3'b000, ord_qty_q})
                                            : -$signed({3'b000, ord_qty_q});
    end
    // Clip against the position as it stands after any handshake completing this cycle.
    pos_eff  = HW'(position_q) + pend_delta;
    headroom = (e_side == SIDE_BUY) ? (MAX_POS_S - pos_eff) : (MAX_POS_S + pos_eff);
    raw_ext  = $signed({3'b000, e_raw_qty});
    if (headroom <= 0) begin
      clip_qty = '0;
    end else if (raw_ext < headroom) begin
      clip_qty = e_raw_qty;
    end else begin
      clip_qty = headroom[QTY_W-1:0];
    end
    take = e_valid && enable && (clip_qty != '0);

    state_d     = state_q;
    ord_valid_d = ord_valid_q;
    ord_side_d  = ord_side_q;
    ord_price_d = ord_price_q;
    ord_qty_d   = ord_qty_q;
    position_d  = position_q;
    drop_cnt_d  = drop_cnt_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          ord_valid_d = 1'b1;
          ord_side_d  = e_side;
          ord_price_d = e_price;
          ord_qty_d   = clip_qty;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          ord_valid_d = 1'b0;
          position_d  = (QTY_W+2)'(pos_eff);
          if (COOLDOWN_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_CYC - 1);
          end
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take && (state_q != ST_IDLE) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ord_valid_q <= 1'b0;
      ord_side_q  <= SIDE_BUY;
      ord_price_q <= '0;
      ord_qty_q   <= '0;
      position_q  <= '0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ord_valid_q <= ord_valid_d;
      ord_side_q  <= ord_side_d;
      ord_price_q <= ord_price_d;
      ord_qty_q   <= ord_qty_d;
      position_q  <= position_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      pos_limit_a: assert ((position_q <= MAX_POS_S) && (position_q >= -MAX_POS_S));
    end
  end

  assign bus.ord_valid = ord_valid_q;
  assign bus.ord_side  = ord_side_q;
  assign bus.ord_price = ord_price_q;
  assign bus.ord_qty   = ord_qty_q;
  assign position      = position_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_strategy_kernel_imb_fsm.sv
// Directed plus randomized checks of the imbalance kernel against an arithmetic reference model.
module tb_strategy_kernel_imb_fsm;

  localparam int PW   = 32;
  localparam int QW   = 32;
  localparam int NUM  = 3;
  localparam int DEN  = 2;
  localparam int SH   = 1;
  localparam int CD   = 16;
  localparam int MAXP = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic signed [QW+1:0] position;
  logic [15:0]          drop_cnt;
  logic                 busy;

  int     n_checks = 0;
  int     n_err    = 0;
  longint m_pos    = 0;
  longint m_drop   = 0;

  strategy_kernel_imb_fsm_if #(.PRICE_W(PW), .QTY_W(QW)) bus ();

  strategy_kernel_imb_fsm #(
    .PRICE_W(PW), .QTY_W(QW), .IMB_NUM(NUM), .IMB_DEN(DEN),
    .QTY_SHIFT(SH), .COOLDOWN_CYC(CD), .MAX_POS(MAXP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .position (position),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference rules: sane book, strict NUM/DEN imbalance, BUY wins ties of both sides.
  function automatic void model_sig(input longint bp, input longint bq, input longint ap, input longint aq,
                                    output bit sig, output bit side, output longint price, output longint raw);
    bit rdy, buy, sell;
    rdy   = (bp != 0) && (ap != 64'h0000_0000_FFFF_FFFF) && (bp < ap);
    buy   = rdy && (bq * DEN > aq * NUM);
    sell  = rdy && (aq * DEN > bq * NUM);
    sig   = buy || sell;
    side  = !buy;
    price = buy ? ap : bp;
    raw   = (buy ? bq : aq) >> SH;
  endfunction

  function automatic longint model_clip(input bit side, input longint raw, input longint pos);
    longint head;
    head = side ? (MAXP + pos) : (MAXP - pos);
    if (head <= 0) return 0;
    return (raw < head) ? raw : head;
  endfunction

  task automatic book(input longint bp, input longint bq, input longint ap, input longint aq);
    bus.book_valid     = 1'b1;
    bus.best_bid_price = PW'(bp);
    bus.best_bid_qty   = QW'(bq);
    bus.best_ask_price = PW'(ap);
    bus.best_ask_qty   = QW'(aq);
  endtask

  // Present one book strobe and advance to the N+2 observation point.
  task automatic send(input longint bp, input longint bq, input longint ap, input longint aq);
    book(bp, bq, ap, aq);
    step();
    bus.book_valid = 1'b0;
    step();
  endtask

  task automatic expect_order(input string tag, input bit side, input longint price, input longint qty);
    chk({tag, "_valid"}, 64'(bus.ord_valid), 1);
    chk({tag, "_side"},  64'(bus.ord_side), 64'(side));
    chk({tag, "_price"}, 64'(bus.ord_price), price);
    chk({tag, "_qty"},   64'(bus.ord_qty), qty);
  endtask

  longint nb_bp [6] = '{102, 0,   100, 101, 100, 100};
  longint nb_bq [6] = '{30,  30,  30,  30,  10,  30};
  longint nb_ap [6] = '{101, 101, 64'hFFFF_FFFF, 101, 101, 101};
  longint nb_aq [6] = '{10,  10,  10,  10,  15,  10};
  bit     nb_en [6] = '{1,   1,   1,   1,   1,   0};

  initial begin
    bus.book_valid = 1'b0;
    bus.best_bid_price = '0;
    bus.best_bid_qty   = '0;
    bus.best_ask_price = '0;
    bus.best_ask_qty   = '0;
    bus.ord_ready      = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    step(2);
    chk("rst_valid", 64'(bus.ord_valid), 0);
    chk("rst_side",  64'(bus.ord_side), 0);
    chk("rst_price", 64'(bus.ord_price), 0);
    chk("rst_qty",   64'(bus.ord_qty), 0);
    chk("rst_pos",   64'(position), 0);
    chk("rst_drop",  64'(drop_cnt), 0);
    chk("rst_busy",  64'(busy), 0);
    rst_n = 1'b1;
    step(2);

    // Basic BUY with ready already high; handshake at N+2.
    bus.ord_ready = 1'b1;
    book(100, 30, 101, 10);
    step();
    bus.book_valid = 1'b0;
    chk("t1_n1_valid", 64'(bus.ord_valid), 0);
    step();
    expect_order("t1", 0, 101, 15);
    chk("t1_busy", 64'(busy), 1);
    step();
    chk("t1_done_valid", 64'(bus.ord_valid), 0);
    chk("t1_pos", 64'(position), 15);
    $display("txn t1: BUY 101 x15 pos=%0d", position);

    // Same book inside cooldown is dropped; cooldown spans exactly CD cycles.
    step(2);
    send(100, 30, 101, 10);
    chk("t2_drop", 64'(drop_cnt), 1);
    chk("t2_busy", 64'(busy), 1);
    step(11);
    chk("t2_cool_last", 64'(busy), 1);
    step();
    chk("t2_cool_end", 64'(busy), 0);
    $display("txn t2: dropped during cooldown drop_cnt=%0d", drop_cnt);

    // After cooldown: clipped to remaining headroom.
    send(100, 30, 101, 10);
    expect_order("t4", 0, 101, 5);
    step();
    chk("t4_pos", 64'(position), 20);
    step(CD);
    send(100, 30, 101, 10);
    chk("t4_full_n2", 64'(bus.ord_valid), 0);
    step();
    chk("t4_full_n3", 64'(bus.ord_valid), 0);
    chk("t4_full_drop", 64'(drop_cnt), 1);
    chk("t4_full_busy", 64'(busy), 0);
    $display("txn t4: clipped BUY x5 then silent discard pos=%0d", position);

    // SELL held for 10 cycles with a book arriving during HOLD.
    bus.ord_ready = 1'b0;
    send(100, 10, 101, 40);
    expect_order("t3", 1, 100, 20);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) book(100, 10, 101, 40);
      if (i == 3) bus.book_valid = 1'b0;
      step();
      expect_order("t3_hold", 1, 100, 20);
      chk("t3_hold_pos", 64'(position), 20);
    end
    chk("t3_drop", 64'(drop_cnt), 2);
    bus.ord_ready = 1'b1;
    step();
    chk("t3_done_valid", 64'(bus.ord_valid), 0);
    chk("t3_pos", 64'(position), 0);
    bus.ord_ready = 1'b0;
    step(CD);
    chk("t3_idle", 64'(busy), 0);
    $display("txn t3: SELL 100 x20 held 10 cycles pos=%0d", position);

    // Books that must never produce an order.
    bus.ord_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      enable = nb_en[k];
      send(nb_bp[k], nb_bq[k], nb_ap[k], nb_aq[k]);
      chk($sformatf("t5_%0d_valid", k), 64'(bus.ord_valid), 0);
      step();
      chk($sformatf("t5_%0d_busy", k), 64'(busy), 0);
      chk($sformatf("t5_%0d_drop", k), 64'(drop_cnt), 2);
      $display("txn t5_%0d: no order", k);
    end
    enable = 1'b1;

    // Evaluation coinciding with a handshake sees the pending qty and is discarded, not dropped.
    bus.ord_ready = 1'b0;
    send(100, 40, 101, 10);
    expect_order("t7", 0, 101, 20);
    book(100, 40, 101, 10);
    step();
    bus.book_valid = 1'b0;
    bus.ord_ready  = 1'b1;
    step();
    chk("t7_done_valid", 64'(bus.ord_valid), 0);
    chk("t7_pos", 64'(position), 20);
    chk("t7_drop", 64'(drop_cnt), 2);
    bus.ord_ready = 1'b0;
    step(CD);
    chk("t7_idle", 64'(busy), 0);
    $display("txn t7: coincident eval discarded pos=%0d", position);

    // Reset while an order is held.
    send(100, 10, 101, 40);
    expect_order("t6", 1, 100, 20);
    step(2);
    chk("t6_still", 64'(bus.ord_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.ord_valid), 0);
    chk("t6_rst_pos",   64'(position), 0);
    chk("t6_rst_drop",  64'(drop_cnt), 0);
    chk("t6_rst_busy",  64'(busy), 0);
    step();
    rst_n = 1'b1;
    step(2);
    chk("t6_rel_busy",  64'(busy), 0);
    chk("t6_rel_valid", 64'(bus.ord_valid), 0);
    $display("txn t6: reset during HOLD");
    m_pos  = 0;
    m_drop = 0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      longint bp, bq, ap, aq, pr, raw, q;
      longint bp2, bq2, ap2, aq2, pr2, raw2, q2;
      bit sig, sd, en, exp_ord, inj, sig2, sd2, en2;
      int d;
      bp  = ($urandom_range(0, 5) == 0) ? 0 : longint'($urandom_range(95, 105));
      ap  = $urandom_range(95, 108);
      bq  = $urandom_range(0, 40);
      aq  = $urandom_range(0, 40);
      en  = ($urandom_range(0, 5) != 0);
      d   = $urandom_range(0, 3);
      inj = $urandom_range(0, 1) == 1;
      model_sig(bp, bq, ap, aq, sig, sd, pr, raw);
      q = sig ? model_clip(sd, raw, m_pos) : 0;
      exp_ord = sig && en && (q > 0);
      enable = en;
      bus.ord_ready = (d == 0);
      send(bp, bq, ap, aq);
      chk($sformatf("r%0d_offer", t), 64'(bus.ord_valid), 64'(exp_ord));
      if (exp_ord) begin
        expect_order($sformatf("r%0d", t), sd, pr, q);
        for (int i = 0; i < d; i++) begin
          step();
          chk($sformatf("r%0d_hold", t), 64'(bus.ord_valid), 1);
          chk($sformatf("r%0d_hold_pos", t), 64'(position), m_pos);
        end
        bus.ord_ready = 1'b1;
        step();
        m_pos = sd ? (m_pos - q) : (m_pos + q);
        chk($sformatf("r%0d_done", t), 64'(bus.ord_valid), 0);
        chk($sformatf("r%0d_pos", t), 64'(position), m_pos);
        bus.ord_ready = 1'b0;
        if (inj) begin
          step();
          bp2 = $urandom_range(95, 100);
          ap2 = $urandom_range(101, 104);
          bq2 = $urandom_range(0, 40);
          aq2 = $urandom_range(0, 40);
          en2 = ($urandom_range(0, 3) != 0);
          enable = en2;
          send(bp2, bq2, ap2, aq2);
          model_sig(bp2, bq2, ap2, aq2, sig2, sd2, pr2, raw2);
          q2 = sig2 ? model_clip(sd2, raw2, m_pos) : 0;
          if (sig2 && en2 && (q2 > 0) && (m_drop < 65535)) m_drop++;
          chk($sformatf("r%0d_inj_drop", t), 64'(drop_cnt), m_drop);
          step(CD - 3);
        end else begin
          step(CD);
        end
        chk($sformatf("r%0d_idle", t), 64'(busy), 0);
      end else begin
        step();
        chk($sformatf("r%0d_idle", t), 64'(busy), 0);
      end
      chk($sformatf("r%0d_drop", t), 64'(drop_cnt), m_drop);
      chk($sformatf("r%0d_pos_end", t), 64'(position), m_pos);
      $display("txn r%0d: book %0d/%0d %0d/%0d en=%0d order=%0d side=%0d qty=%0d pos=%0d drops=%0d",
               t, bp, bq, ap, aq, en, exp_ord, sd, q, m_pos, m_drop);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
